// File: rtl/pipe_hazard_unit_if.sv
// Hazard-unit bundle: pipeline register fields in, stall/flush/forward controls out.
// master = datapath side, slave = pipe_hazard_unit.
interface pipe_hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic [4:0]       idex_rs;
  logic [4:0]       idex_rt;
  logic             idex_MemtoReg;
  logic             idex_RegWrite;
  logic [4:0]       exmem_wreg;
  logic             exmem_RegWrite;
  logic [4:0]       memwb_wreg;
  logic             memwb_RegWrite;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt,
    output idex_rs, idex_rt, idex_MemtoReg, idex_RegWrite,
    output exmem_wreg, exmem_RegWrite,
    output memwb_wreg, memwb_RegWrite,
    output ex_redirect, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_bubble, pipe_hold, fwd_a, fwd_b,
    input  stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt,
    input  idex_rs, idex_rt, idex_MemtoReg, idex_RegWrite,
    input  exmem_wreg, exmem_RegWrite,
    input  memwb_wreg, memwb_RegWrite,
    input  ex_redirect, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush,
    output idex_bubble, pipe_hold, fwd_a, fwd_b,
    output stall_cnt, flush_cnt, wait_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// ID/EX hazard controller: forwarding, load-use stall, redirect flush, dmem wait.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module pipe_hazard_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    BR_FLUSH,
    MEM_WAIT
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       pend_q, pend_d;

  logic load_use, mem_wait;
  logic do_redir, do_freeze, do_lu;
  logic pc_write, ifid_write, ifid_flush;
  logic idex_bubble, pipe_hold;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       em_we,
    input logic [4:0] em_rd,
    input logic       mw_we,
    input logic [4:0] mw_rd
  );
    if (em_we && em_rd != 5'd0 && em_rd == src)
      return 2'b10;
    else if (mw_we && mw_rd != 5'd0 && mw_rd == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign load_use = hz.idex_MemtoReg && hz.idex_RegWrite &&
                    hz.idex_rt != 5'd0 &&
                    (hz.idex_rt == hz.ifid_rs ||
                     (hz.ifid_uses_rt && hz.idex_rt == hz.ifid_rt));
  assign mem_wait = hz.mem_req && !hz.mem_ready;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    pend_d    = pend_q;
    do_redir  = 1'b0;
    do_freeze = 1'b0;
    do_lu     = 1'b0;
    unique case (state_q)
      RUN, LD_STALL: begin
        state_d = RUN;
        if (mem_wait) begin
          do_freeze = 1'b1;
          state_d   = MEM_WAIT;
          if (hz.ex_redirect) pend_d = 1'b1;
        end else if (hz.ex_redirect) begin
          do_redir = 1'b1;
        end else if (load_use && state_q == RUN) begin
          do_lu = 1'b1;
        end
      end
      BR_FLUSH: begin
        if (mem_wait) begin
          do_freeze = 1'b1;
        end else if (hz.ex_redirect) begin
          do_redir = 1'b1;
        end else begin
          fcnt_d = 2'(fcnt_q - 2'd1);
          if (fcnt_q <= 2'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_ready) begin
          do_freeze = 1'b1;
        end else if (pend_q || hz.ex_redirect) begin
          do_redir = 1'b1;
          pend_d   = 1'b0;
        end else if (load_use) begin
          do_lu = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (do_redir) begin
      if (FLUSH_CYCLES > 1) begin
        state_d = BR_FLUSH;
        fcnt_d  = 2'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
      end
    end
    if (do_lu) state_d = LD_STALL;
  end

  // Output decode; reset overrides everything in the same cycle.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = (state_q == BR_FLUSH);
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (do_freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end
    if (do_redir) begin
      pc_write    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
    if (do_lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_hold   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.pipe_hold   = pipe_hold;

  assign hz.fwd_a = rst ? 2'b00 :
    fwd_sel(hz.idex_rs, hz.exmem_RegWrite, hz.exmem_wreg,
            hz.memwb_RegWrite, hz.memwb_wreg);
  assign hz.fwd_b = rst ? 2'b00 :
    fwd_sel(hz.idex_rt, hz.exmem_RegWrite, hz.exmem_wreg,
            hz.memwb_RegWrite, hz.memwb_wreg);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q, wait_q;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Load-use is the only response that bubbles without flushing IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (idex_bubble && !ifid_flush && stall_q != '1)
        stall_q <= stall_q + ONE;
      if (ifid_flush && flush_q != '1)
        flush_q <= flush_q + ONE;
      if (state_q == MEM_WAIT && wait_q != '1)
        wait_q <= wait_q + ONE;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
  assign hz.wait_cnt  = wait_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
  assign hz.wait_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with FLUSH_CYCLES=2.
// Counter expectations follow HAZARD_PERF_EN when it is defined.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   perf;

  pipe_hazard_unit_if #(.CNT_W(32)) hz ();

  pipe_hazard_unit #(
    .FLUSH_CYCLES(2),
    .CNT_W       (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.ifid_rs        = 5'd0;
    hz.ifid_rt        = 5'd0;
    hz.ifid_uses_rt   = 1'b0;
    hz.idex_rs        = 5'd0;
    hz.idex_rt        = 5'd0;
    hz.idex_MemtoReg  = 1'b0;
    hz.idex_RegWrite  = 1'b0;
    hz.exmem_wreg     = 5'd0;
    hz.exmem_RegWrite = 1'b0;
    hz.memwb_wreg     = 5'd0;
    hz.memwb_RegWrite = 1'b0;
    hz.ex_redirect    = 1'b0;
    hz.mem_req        = 1'b0;
    hz.mem_ready      = 1'b0;
  endtask

  // ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, {27'd0, hz.pc_write, hz.ifid_write, hz.ifid_flush,
              hz.idex_bubble, hz.pipe_hold}, {27'd0, exp});
  endtask

  task automatic load_use_inputs(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt);
    hz.idex_rt       = 5'd2;
    hz.idex_MemtoReg = 1'b1;
    hz.idex_RegWrite = 1'b1;
    hz.ifid_rs       = rs;
    hz.ifid_rt       = rt;
    hz.ifid_uses_rt  = uses_rt;
  endtask

  initial begin
`ifdef HAZARD_PERF_EN
    perf = 1;
`else
    perf = 0;
`endif
    idle();
    rst = 1'b1;
    hz.exmem_wreg     = 5'd4;
    hz.exmem_RegWrite = 1'b1;
    hz.idex_rs        = 5'd4;
    tick();
    chk_ctl("reset_ctl", 5'b00110);
    chk("reset_fwd_a", {30'd0, hz.fwd_a}, 32'd0);
    rst = 1'b0;
    idle();
    tick();
    chk_ctl("idle_defaults", 5'b11000);

    load_use_inputs(5'd2, 5'd0, 1'b0);
    chk_ctl("lu_stall", 5'b00010);
    tick();
    chk_ctl("lu_no_second_bubble", 5'b11000);
    idle();
    tick();

    load_use_inputs(5'd5, 5'd2, 1'b0);
    chk_ctl("lu_rt_unused", 5'b11000);
    hz.ifid_uses_rt = 1'b1;
    chk_ctl("lu_rt_used", 5'b00010);
    tick();
    idle();
    tick();

    hz.exmem_wreg     = 5'd3;
    hz.exmem_RegWrite = 1'b1;
    hz.memwb_wreg     = 5'd3;
    hz.memwb_RegWrite = 1'b1;
    hz.idex_rs        = 5'd3;
    hz.idex_rt        = 5'd3;
    #1;
    chk("fwd_a_exmem", {30'd0, hz.fwd_a}, 32'd2);
    chk("fwd_b_exmem", {30'd0, hz.fwd_b}, 32'd2);
    hz.exmem_RegWrite = 1'b0;
    #1;
    chk("fwd_a_memwb", {30'd0, hz.fwd_a}, 32'd1);
    hz.exmem_RegWrite = 1'b1;
    hz.exmem_wreg     = 5'd0;
    #1;
    chk("fwd_a_exmem_r0", {30'd0, hz.fwd_a}, 32'd1);
    hz.idex_rs = 5'd0;
    #1;
    chk("fwd_a_rs0", {30'd0, hz.fwd_a}, 32'd0);
    chk("fwd_b_still_memwb", {30'd0, hz.fwd_b}, 32'd1);
    idle();
    tick();

    hz.ex_redirect = 1'b1;
    chk_ctl("redir_cyc1", 5'b11110);
    tick();
    hz.ex_redirect = 1'b0;
    chk_ctl("redir_cyc2", 5'b11100);
    tick();
    chk_ctl("redir_done", 5'b11000);

    hz.mem_req     = 1'b1;
    hz.ex_redirect = 1'b1;
    chk_ctl("wait_cyc1", 5'b00001);
    tick();
    hz.ex_redirect = 1'b0;
    chk_ctl("wait_cyc2", 5'b00001);
    tick();
    chk_ctl("wait_cyc3", 5'b00001);
    tick();
    hz.mem_ready = 1'b1;
    chk_ctl("wait_release_redir", 5'b11110);
    tick();
    hz.mem_req   = 1'b0;
    hz.mem_ready = 1'b0;
    chk_ctl("wait_post_flush", 5'b11100);
    tick();
    chk_ctl("wait_done", 5'b11000);

    load_use_inputs(5'd2, 5'd0, 1'b0);
    hz.ex_redirect = 1'b1;
    chk_ctl("lu_vs_redir", 5'b11110);
    tick();
    idle();
    chk_ctl("lu_vs_redir_flush2", 5'b11100);
    tick();
    chk_ctl("lu_vs_redir_done", 5'b11000);

    chk("stall_cnt", hz.stall_cnt, perf != 0 ? 32'd2 : 32'd0);
    chk("flush_cnt", hz.flush_cnt, perf != 0 ? 32'd6 : 32'd0);
    chk("wait_cnt",  hz.wait_cnt,  perf != 0 ? 32'd3 : 32'd0);

    hz.mem_req     = 1'b1;
    hz.ex_redirect = 1'b1;
    tick();
    hz.ex_redirect = 1'b0;
    chk_ctl("rst_pre_wait", 5'b00001);
    tick();
    rst = 1'b1;
    chk_ctl("rst_mid_wait", 5'b00110);
    tick();
    rst          = 1'b0;
    hz.mem_req   = 1'b0;
    hz.mem_ready = 1'b1;
    chk_ctl("rst_pend_dropped", 5'b11000);
    chk("rst_stall_cnt", hz.stall_cnt, 32'd0);
    chk("rst_flush_cnt", hz.flush_cnt, 32'd0);
    chk("rst_wait_cnt",  hz.wait_cnt,  32'd0);
    tick();
    chk_ctl("rst_after_run", 5'b11000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
